mdu: RTL and testbench

- Parametrised multi-cycle multiply/divide unit; the next-generation arithmetic block alongside the single-cycle ALU in the pipelined CPU's EX stage.
- Holds the architectural HI/LO registers.
- Executes signed and unsigned mult/div with a fixed, configurable latency; performs mthi/mtlo writes.
- Exposes busy so hazard logic can stall any mfhi/mflo or new MDU instruction.

---
 rtl/mdu.sv | 171 +++++++++++++++++
 tb/tb_mdu.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu -- multi-cycle multiply/divide unit holding the architectural HI/LO pair.
//
// The result is computed in full when an operation is accepted and parked in a
// shadow register. A down-counter then models the fixed latency, and the
// shadow is committed to HI/LO on the edge where the counter reaches zero.
// MTHI/MTLO write immediately and never raise busy.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset (clears HI/LO, aborts in-flight op)
//   start  in   request strobe, accepted only when busy is low
//   op     in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   src_a  in   rs operand / dividend / MTHI-MTLO data
//   src_b  in   rt operand / divisor
//   busy   out  high while a mult/div is in flight
//   done   out  one-cycle pulse in the first cycle new HI/LO are visible
//   hi     out  HI register
//   lo     out  LO register
module mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Arithmetic kernels; each returns {hi, lo}.
  function automatic logic [2*WIDTH-1:0] mul_signed(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] ae;
    logic signed [2*WIDTH-1:0] be;
    logic signed [2*WIDTH-1:0] p;
    ae = {{WIDTH{a[WIDTH-1]}}, a};
    be = {{WIDTH{b[WIDTH-1]}}, b};
    p  = ae * be;
    return p;
  endfunction

  function automatic logic [2*WIDTH-1:0] mul_unsigned(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] ae;
    logic [2*WIDTH-1:0] be;
    ae = {{WIDTH{1'b0}}, a};
    be = {{WIDTH{1'b0}}, b};
    return ae * be;
  endfunction

  // Truncating signed divide; remainder takes the dividend's sign. The
  // most-negative / -1 case is pinned explicitly rather than left to the
  // wrap-around behaviour of the divider. A zero divisor returns zero, and
  // the caller suppresses the write in that case.
  function automatic logic [2*WIDTH-1:0] div_signed(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic signed [WIDTH-1:0] q;
    logic signed [WIDTH-1:0] r;
    logic        [WIDTH-1:0] min_val;
    min_val = {1'b1, {(WIDTH-1){1'b0}}};
    sa = a;
    sb = b;
    if (b == '0) begin
      q = '0;
      r = '0;
    end else if ((a == min_val) && (&b)) begin
      q = min_val;
      r = '0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {r, q};
  endfunction

  function automatic logic [2*WIDTH-1:0] div_unsigned(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    if (b == '0) begin
      q = '0;
      r = '0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic [2*WIDTH-1:0] calc_res;
  logic               calc_wr;
  logic [2*WIDTH-1:0] res_p0;
  logic               wr_p0;

  assign busy   = (cnt != '0);
  assign accept = start && !busy;

  always_comb begin
    calc_res = '0;
    calc_wr  = 1'b0;
    case (op)
      OP_MULT:  begin calc_res = mul_signed(src_a, src_b);   calc_wr = 1'b1;           end
      OP_MULTU: begin calc_res = mul_unsigned(src_a, src_b); calc_wr = 1'b1;           end
      OP_DIV:   begin calc_res = div_signed(src_a, src_b);   calc_wr = (src_b != '0);  end
      OP_DIVU:  begin calc_res = div_unsigned(src_a, src_b); calc_wr = (src_b != '0);  end
      default:  begin calc_res = '0;                          calc_wr = 1'b0;           end
    endcase
  end

  // Stage p0: result shadow captured at accept, held until commit.
  always_ff @(posedge clk) begin
    if (accept) begin
      res_p0 <= calc_res;
      wr_p0  <= calc_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      done <= 1'b0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        case (op)
          OP_MULT, OP_MULTU: cnt <= MULT_N;
          OP_DIV, OP_DIVU:   cnt <= DIV_N;
          OP_MTHI:           hi  <= src_a;
          OP_MTLO:           lo  <= src_a;
          default:           cnt <= '0;
        endcase
      end else if (busy) begin
        cnt <= cnt - CNT_ONE;
        // Commit on the 1->0 transition; a zero divisor leaves HI/LO alone.
        if (cnt == CNT_ONE) begin
          done <= 1'b1;
          if (wr_p0) begin
            {hi, lo} <= res_p0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0;
  logic        start1;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;

  logic        busy0, done0;
  logic [31:0] hi0, lo0;
  logic        busy1, done1;
  logic [31:0] hi1, lo1;

  // Bench-side model of the HI/LO contents for each instance.
  logic [31:0] mh0, ml0, mh1, ml1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .op(op),
    .src_a(src_a), .src_b(src_b),
    .busy(busy0), .done(done0), .hi(hi0), .lo(lo0)
  );

  mdu #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op),
    .src_a(src_a), .src_b(src_b),
    .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one mult/div on instance sel, check busy for exactly n cycles with
  // HI/LO held, then check the done cycle. Returns sampled in the done cycle.
  // poke_mthi injects an MTHI 0x1234 (and changes src_a) mid-flight.
  task automatic run_op(input bit sel, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] eh, input logic [31:0] el,
                        input bit poke_mthi, input string tag);
    logic [31:0] oh, ol;
    oh = sel ? mh1 : mh0;
    ol = sel ? ml1 : ml0;
    op = o; src_a = a; src_b = b;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0; start1 = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, sel ? busy1 : busy0, 1'b1);
      chk({tag, "_nodone"}, sel ? done1 : done0, 1'b0);
      chk({tag, "_hold"}, sel ? {hi1, lo1} : {hi0, lo0}, {oh, ol});
      if (poke_mthi && i == 1) begin
        start0 = 1'b1; op = OP_MTHI; src_a = 32'h1234;
      end else begin
        start0 = 1'b0;
      end
      tick();
    end
    start0 = 1'b0;
    if (sel) begin mh1 = eh; ml1 = el; end
    else     begin mh0 = eh; ml0 = el; end
    chk({tag, "_idle"}, sel ? busy1 : busy0, 1'b0);
    chk({tag, "_done"}, sel ? done1 : done0, 1'b1);
    chk({tag, "_hilo"}, sel ? {hi1, lo1} : {hi0, lo0}, {eh, el});
  endtask

  initial begin
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
    op = 3'd7; src_a = '0; src_b = '0;
    mh0 = '0; ml0 = '0; mh1 = '0; ml1 = '0;
    tick();
    reset = 1'b0;
    chk("rst_busy0", busy0, 1'b0);
    chk("rst_done0", done0, 1'b0);
    chk("rst_hilo0", {hi0, lo0}, 64'h0);
    chk("rst_hilo1", {busy1, done1, hi1, lo1}, 66'h0);

    run_op(1'b0, OP_MULT, 32'hFFFFFFFD, 32'd7, 5, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult");
    tick();
    chk("mult_pulse_end", done0, 1'b0);

    run_op(1'b0, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu");
    tick();
    run_op(1'b0, OP_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_neg");
    tick();
    run_op(1'b0, OP_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b0, "divu");
    tick();
    run_op(1'b0, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000, 1'b0, "div_ovf");
    tick();

    // MTHI during DIV 100/7 is dropped; operands stay latched.
    run_op(1'b0, OP_DIV, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b1, "div_mthi");
    tick();
    chk("div_mthi_after", hi0, 32'd2);

    // Divide by zero keeps HI/LO.
    run_op(1'b0, OP_DIV, 32'd5, 32'd0, 10, 32'd2, 32'd14, 1'b0, "div0");
    tick();

    // MTLO: immediate, no busy, no done.
    op = OP_MTLO; src_a = 32'h0000ABCD; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    ml0 = 32'h0000ABCD;
    chk("mtlo_lo", {hi0, lo0}, {mh0, ml0});
    chk("mtlo_busy", busy0, 1'b0);
    chk("mtlo_done", done0, 1'b0);
    tick();
    chk("mtlo_busy2", busy0, 1'b0);
    chk("mtlo_done2", done0, 1'b0);

    // Back-to-back MULTs: second accepted in the done cycle of the first.
    run_op(1'b0, OP_MULT, 32'd6, 32'd7, 5, 32'd0, 32'd42, 1'b0, "b2b_a");
    run_op(1'b0, OP_MULT, 32'h00010000, 32'h00010000, 5, 32'd1, 32'd0, 1'b0, "b2b_b");
    tick();
    chk("b2b_pulse_end", {busy0, done0}, 2'b00);

    // Reset at busy cycle 3 of a DIV.
    op = OP_DIV; src_a = 32'd9; src_b = 32'd2; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("mid_busy1", busy0, 1'b1);
    tick();
    tick();
    chk("mid_busy3", busy0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mh0 = '0; ml0 = '0; mh1 = '0; ml1 = '0;
    chk("mid_rst_busy", busy0, 1'b0);
    chk("mid_rst_done", done0, 1'b0);
    chk("mid_rst_hilo", {hi0, lo0}, 64'h0);
    for (int i = 0; i < 12; i++) begin
      chk("mid_rst_quiet", {busy0, done0, hi0, lo0}, 66'h0);
      tick();
    end

    // Single-cycle latency instance.
    run_op(1'b1, OP_MULT, 32'd3, 32'd5, 1, 32'd0, 32'd15, 1'b0, "n1_mult");
    tick();
    chk("n1_pulse_end", {busy1, done1}, 2'b00);
    run_op(1'b1, OP_DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0, "n1_divu");
    tick();
    run_op(1'b1, OP_DIV, 32'd1, 32'd0, 1, 32'd2, 32'd14, 1'b0, "n1_div0");
    tick();
    chk("n1_final", {busy1, done1, hi1, lo1}, {2'b00, 32'd2, 32'd14});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
